// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N-way, W-bit registered multiplexer with a 2-entry skid buffer.
//
// Optional feature: define PIPE_MUX_SEL_ERR_EN to build the sticky
// out-of-range select detector driving sel_err. Without it, sel_err is 0.
//
// Handshake (both sides): a beat transfers on a rising clk edge when valid
// and ready are both high. valid never waits on ready. Once valid is raised,
// the payload is held stable until the transfer happens. in_ready is decoded
// from the state register alone, so no combinational path runs from
// out_ready to in_ready.
//
// state_dbg exposes the FSM state (0 EMPTY, 1 ONE, 2 FULL) for observation.
module pipe_mux_n #(
   parameter int W = 8,
   parameter int N = 4,
   parameter logic [W-1:0] DFLT = '0,
   localparam int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SW-1:0]   select,
   input  logic [N*W-1:0]  in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_sel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            sel_err,
   output logic [1:0]      state_dbg
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic          acc;
   logic          rel;
   logic [W-1:0]  beat_data;
   logic [W-1:0]  main_data_q;
   logic [W-1:0]  skid_data_q;
   logic [SW-1:0] main_sel_q;
   logic [SW-1:0] skid_sel_q;
   logic          load_main_in;
   logic          load_main_skid;
   logic          load_skid;

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign acc       = in_valid & in_ready;
   assign rel       = out_valid & out_ready;
   assign out_data  = main_data_q;
   assign out_sel   = main_sel_q;
   assign state_dbg = state_q;

   // Pick the selected channel; a select with no matching channel yields DFLT.
   always_comb begin
      beat_data = DFLT;
      for (int k = 0; k < N; k++) begin
         if (select == SW'(k)) begin
            beat_data = in_data[k*W +: W];
         end
      end
   end

   // Next-state and register-load decode for the EMPTY/ONE/FULL buffer.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (acc) begin
               load_main_in = 1'b1;
               state_d      = ONE;
            end
         end
         ONE: begin
            if (acc && !rel) begin
               load_skid = 1'b1;
               state_d   = FULL;
            end else if (!acc && rel) begin
               state_d = EMPTY;
            end else if (acc && rel) begin
               load_main_in = 1'b1;
            end
         end
         FULL: begin
            // in_ready is low here, so only a release can happen.
            if (rel) begin
               load_main_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Main (head) and skid data registers; reset only for X-free simulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_data_q <= '0;
         main_sel_q  <= '0;
         skid_data_q <= '0;
         skid_sel_q  <= '0;
      end else begin
         if (load_main_in) begin
            main_data_q <= beat_data;
            main_sel_q  <= select;
         end else if (load_main_skid) begin
            main_data_q <= skid_data_q;
            main_sel_q  <= skid_sel_q;
         end
         if (load_skid) begin
            skid_data_q <= beat_data;
            skid_sel_q  <= select;
         end
      end
   end

`ifdef PIPE_MUX_SEL_ERR_EN
   logic sel_oor;
   logic sel_err_q;

   // A select is out of range when it matches none of the N channels.
   always_comb begin
      sel_oor = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (select == SW'(k)) begin
            sel_oor = 1'b0;
         end
      end
   end

   // Sticky flag: set by any accepted out-of-range beat, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err_q <= 1'b0;
      end else if (acc && sel_oor) begin
         sel_err_q <= 1'b1;
      end
   end

   assign sel_err = sel_err_q;
`else
   assign sel_err = 1'b0;
`endif

endmodule
